// File: rtl/spi_frame_master.sv
// SPI mode-0 master: shifts one 40-bit {addr, wdata} frame out and captures 32 bits of read data.
// Define SPI_FRAME_MASTER_MISO_SYNC_EN to pass SPI_MISO through a 2-flop synchronizer.
module spi_frame_master #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [7:0]  Addr,
  input  logic [31:0] Wr_Data,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Rd_Data,
  output logic        SPI_CLK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  localparam int MAXP = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                             : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int TW   = $clog2(MAXP + 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [39:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          miso_s;

`ifdef SPI_FRAME_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync_q;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) miso_sync_q <= '0;
    else          miso_sync_q <= {miso_sync_q[0], SPI_MISO};
  assign miso_s = miso_sync_q[1];
`else
  logic miso_q;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) miso_q <= 1'b0;
    else          miso_q <= SPI_MISO;
  assign miso_s = miso_q;
`endif

  // Timer counts down to zero; the value loaded is the phase length minus one.
  function automatic logic [TW-1:0] phase_last(input state_t s);
    case (s)
      SETUP:       return TW'(CS_SETUP - 1);
      HIGH, LOW:   return TW'(CLK_DIV - 1);
      HOLD, GAP:   return TW'(CS_HOLD - 1);
      default:     return '0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d   = SETUP;
        tx_d      = {Addr, Wr_Data};
        bit_cnt_d = '0;
        rx_d      = '0;
      end
      SETUP: if (timer_q == '0) state_d = HIGH;
      HIGH: if (timer_q == '0) begin
        // The address bits come back as don't-care; only the data phase lands in RX.
        if (bit_cnt_q >= 6'd8) rx_d = {rx_q[30:0], miso_s};
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q < 6'd39) begin
          state_d = LOW;
          tx_d    = {tx_q[38:0], 1'b0};
        end else begin
          state_d = HOLD;
        end
      end
      LOW:  if (timer_q == '0) state_d = HIGH;
      HOLD: if (timer_q == '0) state_d = GAP;
      GAP:  if (timer_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q)    timer_d = phase_last(state_d);
    else if (timer_q != '0)    timer_d = timer_q - 1'b1;
  end

  // Pin and status flops are loaded from next-state values so pins have no comb path.
  always_comb begin
    cs_d      = !(state_d == SETUP || state_d == HIGH || state_d == LOW || state_d == HOLD);
    sclk_d    = (state_d == HIGH);
    mosi_d    = cs_d ? 1'b0 : tx_d[39];
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == GAP) && (timer_d == '0);
    rd_data_d = done_d ? rx_q : rd_data_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Rd_Data  = rd_data_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_CS   = cs_q;
  assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: randomized frames against a responder model and a RAM scoreboard.
module tb_spi_frame_master;

  localparam int CLK_DIV  = 8;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int DONE_CYC = CS_SETUP + 79 * CLK_DIV + 2 * CS_HOLD;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Start;
  logic [7:0]  Addr;
  logic [31:0] Wr_Data;
  logic        Busy, Done, SPI_CLK, SPI_CS, SPI_MOSI;
  logic [31:0] Rd_Data;
  logic        SPI_MISO = 1'b0;
  bit          clk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  spi_frame_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Addr(Addr), .Wr_Data(Wr_Data),
    .Busy(Busy), .Done(Done), .Rd_Data(Rd_Data), .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
  );

  always #10 if (clk_en) Clk = ~Clk;

  // Responder model: edges seen one Clk late, MISO updated after each SPI_CLK fall.
  bit          ram_mode = 1'b0;
  logic [7:0]  pat_pre  = 8'h00;
  logic [31:0] pat_word = 32'h0;
  bit   [31:0] ram [256];
  logic        pclk = 1'b0, pcs = 1'b1;
  logic [39:0] cap = '0;
  logic [31:0] cur_word = '0;
  int          rise_cnt = 0, fall_cnt = 0, we_cnt = 0, done_cnt = 0;

  always @(posedge Clk) begin
    pclk <= SPI_CLK;
    pcs  <= SPI_CS;
    if (Done) done_cnt <= done_cnt + 1;
    if (pcs && !SPI_CS) begin
      rise_cnt <= 0;
      fall_cnt <= 0;
      cap      <= '0;
      SPI_MISO <= pat_pre[7];
    end else if (!SPI_CS) begin
      if (!pclk && SPI_CLK) begin
        cap      <= {cap[38:0], SPI_MOSI};
        rise_cnt <= rise_cnt + 1;
      end
      if (pclk && !SPI_CLK) begin
        fall_cnt <= fall_cnt + 1;
        if (fall_cnt < 7) SPI_MISO <= pat_pre[6 - fall_cnt];
        else if (fall_cnt == 7) begin
          cur_word <= ram_mode ? ram[cap[7:0]] : pat_word;
          SPI_MISO <= ram_mode ? ram[cap[7:0]][31] : pat_word[31];
        end else if (fall_cnt < 39) SPI_MISO <= cur_word[38 - fall_cnt];
        else begin
          SPI_MISO <= 1'b0;
          if (ram_mode) begin
            ram[cap[39:32]] <= cap[31:0];
            we_cnt <= we_cnt + 1;
          end
        end
      end
    end
  end

  bit [31:0] exp_ram [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input string tag);
    int cyc;
    int first_hi;
    @(negedge Clk);
    Addr = a; Wr_Data = d; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    cyc = 1;
    first_hi = -1;
    check({tag, "_busy_c1"}, 64'(Busy), 64'd1);
    check({tag, "_cs_c1"}, 64'(SPI_CS), 64'd0);
    check({tag, "_mosi_c1"}, 64'(SPI_MOSI), 64'(a[7]));
    while (!Done && cyc < 3000) begin
      if (SPI_CLK && first_hi < 0) first_hi = cyc;
      @(negedge Clk);
      cyc++;
    end
    check({tag, "_done"}, 64'(Done), 64'd1);
    check({tag, "_done_cyc"}, 64'(cyc), 64'(DONE_CYC));
    check({tag, "_first_sclk"}, 64'(first_hi), 64'(1 + CS_SETUP));
    check({tag, "_busy_done"}, 64'(Busy), 64'd1);
    check({tag, "_rises"}, 64'(rise_cnt), 64'd40);
    check({tag, "_mosi_frame"}, 64'(cap), 64'({a, d}));
    check({tag, "_rd"}, 64'(Rd_Data), 64'(exp_rd));
    @(negedge Clk);
    check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
    check({tag, "_done_pulse"}, 64'(Done), 64'd0);
  endtask

  task automatic ram_frame(input logic [7:0] a, input logic [31:0] d, input string tag);
    logic [31:0] exp_rd;
    exp_rd = exp_ram[a];
    run_frame(a, d, exp_rd, tag);
    exp_ram[a] = d;
    check({tag, "_ram"}, 64'(ram[a]), 64'(exp_ram[a]));
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d, exp1;
    int cyc, we0, dc0, busy_seen;
    Start = 1'b0; Addr = '0; Wr_Data = '0;

    #2 Reset_n = 1'b0;
    #3;
    check("rst_cs", 64'(SPI_CS), 64'd1);
    check("rst_sclk", 64'(SPI_CLK), 64'd0);
    check("rst_mosi", 64'(SPI_MOSI), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_rd", 64'(Rd_Data), 64'd0);

    clk_en = 1'b1;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    pat_pre = 8'h3C; pat_word = 32'h12345678;
    run_frame(8'h5A, 32'hDEADBEEF, 32'h12345678, "vec");

    pat_pre = 8'hFF; pat_word = 32'h0;
    run_frame(8'($urandom), $urandom, 32'h0, "miso_hdr");

    for (int i = 0; i < 3; i++) begin
      pat_pre = 8'($urandom); pat_word = $urandom;
      run_frame(8'($urandom), $urandom, pat_word, "rand_pat");
    end

    ram_mode = 1'b1;
    ram_frame(8'h03, 32'hCAFEF00D, "ram_wr");
    ram_frame(8'h03, 32'h0, "ram_rd");
    check("ram3_cleared", 64'(ram[3]), 64'd0);
    for (int i = 0; i < 4; i++)
      ram_frame(8'($urandom_range(0, 7)), $urandom, "rand_ram");

    // Start held high: back-to-back frames, extra pulses during Busy ignored.
    a = 8'h11; d = $urandom; exp1 = exp_ram[a]; dc0 = done_cnt;
    @(negedge Clk);
    Addr = a; Wr_Data = d; Start = 1'b1;
    cyc = 0;
    while (!Done && cyc < 3000) begin @(negedge Clk); cyc++; end
    check("held_done1", 64'(Done), 64'd1);
    check("held_rd1", 64'(Rd_Data), 64'(exp1));
    exp_ram[a] = d;
    @(negedge Clk);
    check("held_idle_gap", 64'(Busy), 64'd0);
    @(negedge Clk);
    check("held_reaccept", 64'(Busy), 64'd1);
    check("held_cs", 64'(SPI_CS), 64'd0);
    repeat (3) begin
      repeat (50) @(negedge Clk);
      Start = 1'b0;
      repeat (5) @(negedge Clk);
      Start = 1'b1;
    end
    Start = 1'b0;
    cyc = 0;
    while (!Done && cyc < 3000) begin @(negedge Clk); cyc++; end
    check("held_done2", 64'(Done), 64'd1);
    check("held_rd2", 64'(Rd_Data), 64'(d));
    busy_seen = 0;
    repeat (100) begin @(negedge Clk); if (Busy) busy_seen++; end
    check("held_no_extra", 64'(busy_seen), 64'd0);
    check("held_done_cnt", 64'(done_cnt - dc0), 64'd2);

    // Reset in the middle of the data phase.
    we0 = we_cnt; dc0 = done_cnt;
    @(negedge Clk);
    Addr = 8'h05; Wr_Data = $urandom; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    cyc = 0;
    while (rise_cnt < 20 && cyc < 2000) begin @(negedge Clk); cyc++; end
    check("rst_mid_reached", 64'(rise_cnt >= 20), 64'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("rst_mid_cs", 64'(SPI_CS), 64'd1);
    check("rst_mid_sclk", 64'(SPI_CLK), 64'd0);
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_done", 64'(Done), 64'd0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (50) @(negedge Clk);
    check("rst_mid_no_we", 64'(we_cnt), 64'(we0));
    check("rst_mid_no_done", 64'(done_cnt), 64'(dc0));
    check("rst_mid_rd", 64'(Rd_Data), 64'd0);
    ram_frame(8'h05, $urandom, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_master.md
# spi_frame_master

SPI master issuing the 40-bit address+data frame that the board's `spi_slave` consumes, so the FPGA can act as initiator. Use cases are loopback self-test of the slave path and FPGA-to-FPGA links. Each transaction shifts out an 8-bit address followed by 32 bits of write data, MSB first. It captures the 32 bits the responder returns during the data phase and reports completion with a one-cycle pulse.

## Interface
Parameters:
- `CLK_DIV`, default 8: SPI_CLK half-period in `Clk` cycles. Legal range is 4 or more, which covers the responder's synchronizer delay.
- `CS_SETUP`, default 4: `Clk` cycles from SPI_CS falling to the first SPI_CLK rising edge.
- `CS_HOLD`, default 4: `Clk` cycles from the last SPI_CLK falling edge to SPI_CS rising. The same count sets the minimum SPI_CS-high gap before Done. Legal range is 4 or more.

Ports (one clock; reset is asynchronous and active-low):
- `Clk`  in  1  system clock, 50 MHz
- `Reset_n`  in  1  asynchronous active-low reset
- `Start`  in  1  request a transaction; sampled only in IDLE
- `Addr`  in  8  frame address, latched at Start acceptance
- `Wr_Data`  in  32  frame payload, latched at Start acceptance
- `Busy`  out  1  high from the cycle after acceptance through the Done cycle
- `Done`  out  1  one-cycle pulse at transaction end
- `Rd_Data`  out  32  data captured from SPI_MISO; holds its value until the next Done
- `SPI_CLK`  out  1  serial clock, idle low (mode 0)
- `SPI_CS`  out  1  chip select, active low
- `SPI_MOSI`  out  1  serial data to the responder
- `SPI_MISO`  in  1  serial data from the responder

## Operation
- All SPI outputs come straight from flops; there is no combinational path to the pins.
- The frame is 40 bits: `{Addr, Wr_Data}`, MSB first on SPI_MOSI.
- SPI_MOSI changes only while SPI_CLK is low. The responder samples on the rising edge.
- SPI_MISO bits 1–8 are ignored. Bits 9–40 are shifted into the receive register MSB first and become `Rd_Data[31:0]`.
- Every frame is a combined read and write: the responder returns the data at `Addr` and stores `Wr_Data` at `Addr`.
- State machine states:
  - IDLE: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0. `Start`=1 latches `{Addr,Wr_Data}` into the 40-bit TX shift register, clears the bit counter, and moves to SETUP.
  - SETUP: SPI_CS=0, SPI_MOSI=tx[39]. Lasts CS_SETUP cycles, then moves to HIGH.
  - HIGH: SPI_CLK=1 for CLK_DIV cycles.
    - On the last cycle, if the bit counter is 8 or more, the sampled MISO value is shifted into RX.
    - The bit counter increments on exit.
    - Exit goes to LOW when the counter is below 39, otherwise to HOLD.
  - LOW: SPI_CLK=0. On entry, TX shifts left so SPI_MOSI carries the next bit. Lasts CLK_DIV cycles, then moves to HIGH.
  - HOLD: SPI_CS=0, SPI_CLK=0 for CS_HOLD cycles. This lets the responder detect the 40th falling edge and commit the write.
  - GAP: SPI_CS=1 for CS_HOLD cycles. On the last cycle, `Rd_Data`<=RX, `Done`=1, and the FSM returns to IDLE.
- Counters:
  - 6-bit bit counter.
  - Phase timer wide enough for max(CLK_DIV, CS_SETUP, CS_HOLD). It reloads on every state change and never wraps mid-phase.
- `Start` while Busy is ignored; there is no queueing. If `Start` is held high, the next frame is accepted in the IDLE cycle after Done.

## Timing
- Reset values, applied asynchronously with no clock needed:
  - SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, Busy=0, Done=0, Rd_Data=0.
  - State is IDLE; TX, RX and the counters are cleared.
- Reset in mid-frame: SPI_CS rises immediately with no Done pulse. The responder sees an incomplete frame and performs no write.
- Acceptance edge is cycle 0. In cycle 1, Busy=1, SPI_CS=0, SPI_MOSI=Addr[7].
- First SPI_CLK rising edge: cycle 1+CS_SETUP.
- Busy duration: CS_SETUP + 79·CLK_DIV + 2·CS_HOLD cycles, which is 644 at the defaults. Done coincides with the last Busy cycle.
- Exactly 40 SPI_CLK rising edges per frame.
- MISO sampling point: the end of the HIGH phase, at least 2·CLK_DIV−1 cycles after the responder's update edge.

## Configuration
- `SPI_FRAME_MASTER_MISO_SYNC_EN` defined:
  - SPI_MISO passes through a 2-flop synchronizer before sampling, adding 2 cycles of sampling latency.
  - The sampling margin still holds for CLK_DIV of 4 or more.
- Not defined: SPI_MISO is sampled through a single register stage.
- Frame timing and Busy duration are identical in both builds.

## Test plan
- Reset asserted with Clk stopped: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, Busy=0, Done=0, Rd_Data=0.
- `Start` with Addr=0x5A and Wr_Data=0xDEADBEEF, MISO model returning 0x12345678 on bits 9–40:
  - SPI_MOSI captured on SPI_CLK rising edges = 0x5ADEADBEEF.
  - 40 rising edges.
  - Done in cycle 644.
  - Rd_Data=0x12345678.
- Linked to `spi_slave` with a RAM model: write 0xCAFEF00D to address 0x03, then transact to 0x03 with Wr_Data=0 → second Rd_Data=0xCAFEF00D; RAM[3]=0 afterwards.
- MISO model drives 1 during bits 1–8 and 0 thereafter → Rd_Data=0x00000000.
- `Start` held high for two frames:
  - Second acceptance occurs exactly 1 cycle after Done.
  - Pulses of `Start` during Busy cause no extra frame.
- Reset_n pulsed low at bit 20:
  - SPI_CS=1 asynchronously, with no Done.
  - Linked `spi_slave` never asserts RAM_we.
  - The next frame completes normally.
